// File: rtl/i2c_burst_reader_pkg.sv
// i2c_burst_reader_pkg -- shared states, R/W bit values and bit-phase encodings. Rev 1.0
`default_nettype none

package i2c_burst_reader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_START  = 4'd1,
      ST_WADDR  = 4'd2,
      ST_WACK   = 4'd3,
      ST_WREG   = 4'd4,
      ST_WACK2  = 4'd5,
      ST_RSTART = 4'd6,
      ST_RADDR  = 4'd7,
      ST_RACK   = 4'd8,
      ST_RDATA  = 4'd9,
      ST_MACK   = 4'd10,
      ST_STOP   = 4'd11
   } state_t;

   localparam logic I2C_WR = 1'b0;
   localparam logic I2C_RD = 1'b1;

   localparam logic [1:0] P0 = 2'd0;
   localparam logic [1:0] P1 = 2'd1;
   localparam logic [1:0] P2 = 2'd2;
   localparam logic [1:0] P3 = 2'd3;

   function automatic logic [3:0] clamp_nbytes(input logic [3:0] n, input logic [3:0] max_n);
      return (n > max_n) ? max_n : n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_burst_reader_phase_tick.sv
// i2c_phase_tick -- QDIV divider and 2-bit quarter-bit phase counter; held at phase 0 while disabled. Rev 1.0
`default_nettype none

module i2c_phase_tick #(
   parameter int QDIV = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       tick,
   output logic [1:0] phase
);

   localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    phase_q, phase_d;

   assign tick  = en && (cnt_q == CW'(QDIV - 1));
   assign phase = phase_q;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!en) begin
         cnt_d   = '0;
         phase_d = 2'd0;
      end else if (tick) begin
         cnt_d   = '0;
         phase_d = phase_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 2'd0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/i2c_burst_reader.sv
// i2c_burst_reader -- I2C master running START/dev+W/reg/RSTART/dev+R/N bytes/STOP, streaming bytes out. Rev 1.0
`default_nettype none

module i2c_burst_reader
   import i2c_burst_reader_pkg::*;
#(
   parameter int QDIV      = 25,
   parameter int MAX_BYTES = 14
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [3:0] nbytes,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       byte_valid,
   output logic [7:0] byte_out,
   output logic [3:0] byte_idx,
   input  logic       SDA_in,
   output logic       SDA_out,
   output logic       SDA_oen,
   output logic       SCL
);

   state_t     state_q, state_d;
   logic [6:0] dev_q, dev_d;
   logic [7:0] reg_q, reg_d;
   logic [3:0] nb_q, nb_d;
   logic [7:0] sh_q, sh_d;
   logic [2:0] bit_q, bit_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] bout_q, bout_d;
   logic       busy_q, busy_d, done_q, done_d, err_q, err_d, bv_q, bv_d;
   logic       tick, bit_end, sample, scl_w, drv_w;
   logic [1:0] phase;

   i2c_phase_tick #(.QDIV(QDIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .en    (state_q != ST_IDLE),
      .tick  (tick),
      .phase (phase)
   );

   assign bit_end = tick && (phase == P3);
   assign sample  = tick && (phase == P2);

   always_comb begin
      state_d = state_q;
      dev_d   = dev_q;
      reg_d   = reg_q;
      nb_d    = nb_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      idx_d   = bv_q ? idx_q + 4'd1 : idx_q;
      bout_d  = bout_q;
      busy_d  = busy_q;
      err_d   = err_q;
      done_d  = 1'b0;
      bv_d    = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_START;
            dev_d   = dev_addr;
            reg_d   = reg_addr;
            nb_d    = clamp_nbytes(nbytes, 4'(MAX_BYTES));
            sh_d    = {dev_addr, I2C_WR};
            bit_d   = 3'd0;
            idx_d   = 4'd0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
         end
         ST_START: if (bit_end) state_d = ST_WADDR;
         ST_WADDR, ST_WREG, ST_RADDR: if (bit_end) begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7)
               state_d = (state_q == ST_WADDR) ? ST_WACK :
                         (state_q == ST_WREG)  ? ST_WACK2 : ST_RACK;
         end
         // A NACK sampled at the end of p2 is already in err_q by the bit end.
         ST_WACK, ST_WACK2, ST_RACK: begin
            if (sample && SDA_in) err_d = 1'b1;
            if (bit_end) begin
               if (err_q)                   state_d = ST_STOP;
               else if (state_q == ST_WACK) begin
                  state_d = ST_WREG;
                  sh_d    = reg_q;
               end else if (state_q == ST_RACK) state_d = ST_RDATA;
               else if (nb_q == 4'd0)           state_d = ST_STOP;
               else                             state_d = ST_RSTART;
            end
         end
         ST_RSTART: if (bit_end) begin
            state_d = ST_RADDR;
            sh_d    = {dev_q, I2C_RD};
         end
         ST_RDATA: begin
            if (sample) begin
               sh_d = {sh_q[6:0], SDA_in};
               if (bit_q == 3'd7) begin
                  bv_d   = 1'b1;
                  bout_d = {sh_q[6:0], SDA_in};
               end
            end
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_MACK;
            end
         end
         ST_MACK: if (bit_end) state_d = (idx_q == nb_q) ? ST_STOP : ST_RDATA;
         ST_STOP: if (bit_end) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // drv_w = pull SDA low; SDA is otherwise released to the pull-up.
   always_comb begin
      scl_w = 1'b1;
      drv_w = 1'b0;
      case (state_q)
         ST_START: drv_w = (phase >= P2);
         ST_WADDR, ST_WREG, ST_RADDR: begin
            scl_w = (phase >= P2);
            drv_w = ~sh_q[7];
         end
         ST_WACK, ST_WACK2, ST_RACK, ST_RDATA: scl_w = (phase >= P2);
         ST_MACK: begin
            scl_w = (phase >= P2);
            drv_w = (idx_q != nb_q);
         end
         ST_RSTART: begin
            scl_w = (phase != P0);
            drv_w = (phase >= P2);
         end
         ST_STOP: begin
            scl_w = (phase != P0);
            drv_w = (phase <= P1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dev_q   <= '0;
         reg_q   <= '0;
         nb_q    <= '0;
         sh_q    <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         bout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         nb_q    <= nb_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         bv_q    <= bv_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign ack_err    = err_q;
   assign byte_valid = bv_q;
   assign byte_out   = bout_q;
   assign byte_idx   = idx_q;
   assign SCL        = scl_w;
   assign SDA_oen    = drv_w;
   assign SDA_out    = ~drv_w;

endmodule

`default_nettype wire
